// File: rtl/value_editor_pkg.sv
// Shared types for the value editor: step-size states, step lookup and edit direction.
package value_editor_pkg;

   localparam int StepW = 7;

   typedef enum logic [1:0] {
      Step1   = 2'd0,
      Step10  = 2'd1,
      Step100 = 2'd2
   } step_state_e;

   typedef enum logic [1:0] {
      DirNone = 2'd0,
      DirUp   = 2'd1,
      DirDown = 2'd2
   } dir_e;

   function automatic logic [StepW-1:0] step_value(input step_state_e state);
      case (state)
         Step1:   step_value = 7'd1;
         Step10:  step_value = 7'd10;
         Step100: step_value = 7'd100;
         default: step_value = 7'd1;
      endcase
   endfunction

endpackage

// File: rtl/value_editor_accel.sv
// Step-size acceleration: widens the step during long same-direction repeat trains,
// falls back to a step of 1 on direction change, sign toggle or idle timeout.
module value_editor_accel
   import value_editor_pkg::*;
#(
   parameter int StreakLength = 8,
   parameter int IdleCycles   = 15_000_000
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             step_valid,
   input  logic [1:0]       dir,
   input  logic             sign_toggle,
   output logic [StepW-1:0] step_size
);

   localparam int StreakW = $clog2(StreakLength + 1);
   localparam int IdleW   = $clog2(IdleCycles + 1);

   step_state_e        state_r, state_s;
   dir_e               last_dir_r, last_dir_s;
   logic [StreakW-1:0] streak_r, streak_s;
   logic [IdleW-1:0]   idle_r, idle_s;
   logic               dir_change_s;

   // A reversal is applied with a step of 1 regardless of the current state.
   always_comb begin
      dir_change_s = step_valid && (last_dir_r != DirNone) && (dir != last_dir_r);
      if (dir_change_s) begin
         step_size = 7'd1;
      end else begin
         step_size = step_value(state_r);
      end
   end

   // Next-state logic for the step FSM, streak counter and idle counter.
   always_comb begin
      state_s    = state_r;
      last_dir_s = last_dir_r;
      streak_s   = streak_r;
      idle_s     = idle_r;
      if (step_valid) begin
         idle_s     = {IdleW{1'b0}};
         last_dir_s = dir_e'(dir);
         if (dir_change_s) begin
            state_s  = Step1;
            streak_s = {StreakW{1'b0}};
         end else if (streak_r == StreakW'(StreakLength - 1)) begin
            streak_s = {StreakW{1'b0}};
            case (state_r)
               Step1:   state_s = Step10;
               Step10:  state_s = Step100;
               Step100: state_s = Step100;
               default: state_s = Step1;
            endcase
         end else begin
            streak_s = streak_r + StreakW'(1);
         end
      end else begin
         // The timeout fires on the edge where the idle count reaches its limit.
         if (sign_toggle || (idle_r >= IdleW'(IdleCycles - 1))) begin
            state_s  = Step1;
            streak_s = {StreakW{1'b0}};
         end else begin
            state_s  = state_r;
            streak_s = streak_r;
         end
         if (idle_r != IdleW'(IdleCycles)) begin
            idle_s = idle_r + IdleW'(1);
         end else begin
            idle_s = idle_r;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r    <= Step1;
         last_dir_r <= DirNone;
         streak_r   <= {StreakW{1'b0}};
         idle_r     <= {IdleW{1'b0}};
      end else begin
         state_r    <= state_s;
         last_dir_r <= last_dir_s;
         streak_r   <= streak_s;
         idle_r     <= idle_s;
      end
   end

endmodule

// File: rtl/value_editor.sv
// Sign-magnitude value register edited by Up/Down/Sign pulses with symmetric saturation.
// Optional step acceleration is built when VALUE_EDITOR_ACCEL_EN is defined.
module value_editor
   import value_editor_pkg::*;
#(
   parameter int ClockPeriod_ns = 20,
   parameter int MaxMagnitude   = 9999,
   parameter int InitMagnitude  = 0,
   parameter int StreakLength   = 8,
   parameter int IdleTimeout_ns = 300_000_000
) (
   input  logic                              Clock,
   input  logic                              Reset,
   input  logic                              iUp,
   input  logic                              iDown,
   input  logic                              iSigned,
   output logic [$clog2(MaxMagnitude+1)-1:0] oMagnitude,
   output logic                              oNegative,
   output logic                              oUpdate,
   output logic                              oAtLimit
);

   localparam int MagW       = $clog2(MaxMagnitude + 1);
   localparam int SumW       = ((MagW > StepW) ? MagW : StepW) + 2;
   localparam int IdleCycles = IdleTimeout_ns / ClockPeriod_ns;
   localparam logic [MagW-1:0]        MaxMag  = MagW'(MaxMagnitude);
   localparam logic [MagW-1:0]        InitMag = MagW'(InitMagnitude);
   localparam logic signed [SumW-1:0] MaxV    = SumW'(MaxMagnitude);

   logic [MagW-1:0]        mag_r, next_mag_s;
   logic                   neg_r, next_neg_s, update_r, at_limit_r, changed_s;
   logic                   step_valid_s;
   logic [StepW-1:0]       step_size_s;
   logic signed [SumW-1:0] mag_v_s, step_v_s, cur_v_s, sum_v_s, sat_v_s, abs_v_s;

   // A sign pulse swallows any step in the same cycle; opposing steps cancel.
   assign step_valid_s = (iUp ^ iDown) & ~iSigned;

`ifdef VALUE_EDITOR_ACCEL_EN
   logic [1:0] dir_s;
   assign dir_s = iUp ? DirUp : DirDown;

   value_editor_accel #(
      .StreakLength (StreakLength),
      .IdleCycles   (IdleCycles)
   ) u_accel (
      .Clock       (Clock),
      .Reset       (Reset),
      .step_valid  (step_valid_s),
      .dir         (dir_s),
      .sign_toggle (iSigned),
      .step_size   (step_size_s)
   );
`else
   assign step_size_s = 7'd1;
`endif

   // Signed add with saturation, then split back into sign and magnitude.
   always_comb begin
      mag_v_s  = $signed({{(SumW-MagW){1'b0}}, mag_r});
      step_v_s = $signed({{(SumW-StepW){1'b0}}, step_size_s});
      cur_v_s  = neg_r ? -mag_v_s : mag_v_s;
      sum_v_s  = iUp ? (cur_v_s + step_v_s) : (cur_v_s - step_v_s);
      if (sum_v_s > MaxV) begin
         sat_v_s = MaxV;
      end else if (sum_v_s < -MaxV) begin
         sat_v_s = -MaxV;
      end else begin
         sat_v_s = sum_v_s;
      end
      abs_v_s    = sat_v_s[SumW-1] ? -sat_v_s : sat_v_s;
      next_mag_s = mag_r;
      next_neg_s = neg_r;
      if (iSigned) begin
         if (mag_r != {MagW{1'b0}}) begin
            next_neg_s = ~neg_r;
         end else begin
            next_neg_s = neg_r;
         end
      end else if (step_valid_s) begin
         // A zero result has a clear sign bit, so zero stays positive.
         next_mag_s = abs_v_s[MagW-1:0];
         next_neg_s = sat_v_s[SumW-1];
      end else begin
         next_mag_s = mag_r;
         next_neg_s = neg_r;
      end
      changed_s = (next_mag_s != mag_r) || (next_neg_s != neg_r);
   end

   // Output registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         mag_r      <= InitMag;
         neg_r      <= 1'b0;
         update_r   <= 1'b0;
         at_limit_r <= (InitMag == MaxMag);
      end else begin
         mag_r      <= next_mag_s;
         neg_r      <= next_neg_s;
         update_r   <= changed_s;
         at_limit_r <= (next_mag_s == MaxMag);
      end
   end

   assign oMagnitude = mag_r;
   assign oNegative  = neg_r;
   assign oUpdate    = update_r;
   assign oAtLimit   = at_limit_r;

endmodule

// File: tb/tb_value_editor.sv
// Directed self-checking bench for value_editor; expectations follow VALUE_EDITOR_ACCEL_EN.
module tb_value_editor;

   logic       Clock   = 1'b0;
   logic       Reset   = 1'b1;
   logic       iUp     = 1'b0;
   logic       iDown   = 1'b0;
   logic       iSigned = 1'b0;
   logic [6:0] oMagnitude;
   logic       oNegative, oUpdate, oAtLimit;

   int n_checks = 0;
   int n_errors = 0;

   value_editor #(
      .ClockPeriod_ns (20),
      .MaxMagnitude   (99),
      .InitMagnitude  (0),
      .StreakLength   (4),
      .IdleTimeout_ns (2000)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .iUp        (iUp),
      .iDown      (iDown),
      .iSigned    (iSigned),
      .oMagnitude (oMagnitude),
      .oNegative  (oNegative),
      .oUpdate    (oUpdate),
      .oAtLimit   (oAtLimit)
   );

   always #10 Clock = ~Clock;

   task automatic check_value(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sval();
      return oNegative ? -int'(oMagnitude) : int'(oMagnitude);
   endfunction

   // Called at a negedge; returns at the next negedge with the result visible.
   task automatic apply(input logic u, input logic d, input logic s);
      iUp = u; iDown = d; iSigned = s;
      @(posedge Clock);
      #1;
      iUp = 1'b0; iDown = 1'b0; iSigned = 1'b0;
      @(negedge Clock);
   endtask

   task automatic expect_state(input string tag, input int v, input int upd);
      check_value({tag, ".val"}, sval(), v);
      check_value({tag, ".upd"}, int'(oUpdate), upd);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
   endtask

   int exp_up10[10];
   int exp_up6[6];
   int exp_down1;

   initial begin
`ifdef VALUE_EDITOR_ACCEL_EN
      exp_up10 = '{-6, -5, -4, -3, -2, 8, 18, 28, 38, 99};
      exp_up6  = '{1, 2, 3, 4, 14, 24};
      exp_down1 = 23;
`else
      exp_up10 = '{-6, -5, -4, -3, -2, -1, 0, 1, 2, 3};
      exp_up6  = '{1, 2, 3, 4, 5, 6};
      exp_down1 = 5;
`endif
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      expect_state("reset", 0, 0);
      check_value("reset.neg", int'(oNegative), 0);
      check_value("reset.lim", int'(oAtLimit), 0);
      Reset = 1'b0;
      @(negedge Clock);

      // Back-to-back increments, each strobing exactly once.
      for (int i = 1; i <= 3; i++) begin
         apply(1'b1, 1'b0, 1'b0);
         expect_state($sformatf("up3_%0d", i), i, 1);
      end
      @(negedge Clock);
      check_value("up3.strobe_gone", int'(oUpdate), 0);
      check_value("up3.hold", sval(), 3);

      // Sign toggle, decrements and a zero crossing.
      do_reset();
      apply(1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 1'b0);
      expect_state("to2", 2, 1);
      apply(1'b0, 1'b0, 1'b1);
      expect_state("sign2", -2, 1);
      for (int i = 1; i <= 5; i++) begin
         apply(1'b0, 1'b1, 1'b0);
         expect_state($sformatf("down5_%0d", i), -2 - i, 1);
      end
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, 1'b0, 1'b0);
         expect_state($sformatf("up10_%0d", i), exp_up10[i], 1);
         if (exp_up10[i] == 0) begin
            check_value("zero.neg", int'(oNegative), 0);
         end
      end

      // Streak widening followed by a reversal.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, 1'b0, 1'b0);
         expect_state($sformatf("up6_%0d", i), exp_up6[i], 1);
      end
      apply(1'b0, 1'b1, 1'b0);
      expect_state("reverse", exp_down1, 1);

      // Idle gap long enough to time out the widened step.
      do_reset();
      repeat (4) apply(1'b1, 1'b0, 1'b0);
      repeat (100) @(negedge Clock);
      apply(1'b1, 1'b0, 1'b0);
      expect_state("after_idle", 5, 1);

      // Climb to 95 with sign double-toggles keeping the step at 1.
      do_reset();
      for (int i = 0; i < 95; i++) begin
         apply(1'b1, 1'b0, 1'b0);
         apply(1'b0, 1'b0, 1'b1);
         apply(1'b0, 1'b0, 1'b1);
      end
      check_value("at95", sval(), 95);
      for (int i = 1; i <= 4; i++) begin
         apply(1'b1, 1'b0, 1'b0);
         expect_state($sformatf("climb_%0d", i), 95 + i, 1);
         check_value($sformatf("climb_%0d.lim", i), int'(oAtLimit), (i == 4) ? 1 : 0);
      end
      apply(1'b1, 1'b0, 1'b0);
      expect_state("push_limit", 99, 0);
      check_value("push_limit.lim", int'(oAtLimit), 1);
      apply(1'b0, 1'b0, 1'b1);
      expect_state("neg_limit", -99, 1);
      check_value("neg_limit.lim", int'(oAtLimit), 1);
      apply(1'b0, 1'b1, 1'b0);
      expect_state("push_neg_limit", -99, 0);

      // Same-cycle priority corners.
      apply(1'b1, 1'b1, 1'b0);
      expect_state("up_and_down", -99, 0);
      apply(1'b1, 1'b0, 1'b1);
      expect_state("sign_and_up", 99, 1);

      do_reset();
      apply(1'b0, 1'b0, 1'b1);
      expect_state("sign_zero", 0, 0);
      check_value("sign_zero.neg", int'(oNegative), 0);
      apply(1'b1, 1'b0, 1'b0);
      expect_state("pre_rst", 1, 1);

      // Reset beats a simultaneous increment.
      Reset = 1'b1; iUp = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0; iUp = 1'b0;
      @(negedge Clock);
      expect_state("rst_with_up", 0, 0);
      check_value("rst_with_up.lim", int'(oAtLimit), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/value_editor.md
# value_editor

Button-driven signed-value register sitting directly downstream of the front-panel pulse generator. Consumes its single-cycle Up/Down/Sign pulses, including auto-repeat trains, and schedules edits to a sign-magnitude value with saturation. An optional acceleration sequencer widens the step size during long same-direction repeat trains. Output value and update strobe feed the display/decimal-conversion path.

## Interface
- ClockPeriod_ns, 20: clock period; used only for the idle-timeout cycle count.
- MaxMagnitude, 9999: saturation limit, applied symmetrically to ±MaxMagnitude.
- InitMagnitude, 0: magnitude loaded on reset. Sign on reset is always positive.
- StreakLength, 8: number of consecutive accepted same-direction steps before the step size widens.
- IdleTimeout_ns, 300_000_000: gap without an accepted step after which the step size returns to 1.
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- iUp  in  1  active-high, one-cycle increment pulse.
- iDown  in  1  active-high, one-cycle decrement pulse.
- iSigned  in  1  active-high, one-cycle sign-toggle pulse.
- oMagnitude  out  $clog2(MaxMagnitude+1)  current magnitude.
- oNegative  out  1  sign; 1 means negative.
- oUpdate  out  1  one-cycle strobe; high when the value changed on the previous edge.
- oAtLimit  out  1  high while oMagnitude == MaxMagnitude.

## Operation
- Reset values: oMagnitude=InitMagnitude, oNegative=0, oUpdate=0, oAtLimit=(InitMagnitude==MaxMagnitude), step state Step1, streak counter 0, idle counter 0.
- Reset wins over every input in the same cycle.
- Input priority within one cycle:
  - iSigned applies the toggle; any iUp/iDown in that cycle is dropped.
  - iUp and iDown together, without iSigned: both are ignored.
- Step arithmetic is on the signed value V = ±magnitude. Up gives V+step; Down gives V−step.
- Zero crossing is exact. Example: −3 Up with step 10 gives +7.
- The result saturates at ±MaxMagnitude.
- Zero is always positive: oNegative is forced to 0 whenever the magnitude is 0.
- Sign toggle on zero magnitude is a no-op.
- oUpdate fires only when magnitude or sign actually changes. Pushing further while at the limit, or toggling the sign of zero, gives no strobe.
- Acceleration FSM (ACCEL_EN only) has states Step1 → Step10 → Step100. Step100 holds.
  - The streak counter increments on each accepted step pulse in the same direction as the previous one.
  - When the streak reaches StreakLength: advance one state and clear the streak.
  - A direction change, an accepted iSigned, or an idle timeout sends the FSM to Step1 with streak 0.
  - A direction change still applies the new step; the step size used is 1.
- Idle counter:
  - Clears on each accepted step pulse.
  - Counts otherwise and saturates at IdleTimeout_ns/ClockPeriod_ns.
  - On reaching that value: FSM goes to Step1 and the streak clears.

## Timing
- An input pulse sampled at edge N shows its new oMagnitude/oNegative/oAtLimit after edge N, with oUpdate high for exactly that one cycle.
- Back-to-back pulses on consecutive cycles are each applied. There is no dropped-pulse window.
- The step size used for a pulse is the FSM state before that edge. A widening takes effect on the following pulse.
- The timeout check and a step pulse in the same cycle: the pulse wins, the idle counter clears, and the FSM is not reset.

## Configuration
- VALUE_EDITOR_ACCEL_EN defined: the acceleration FSM, streak counter and idle counter are built as specified above.
- Undefined: step is fixed at 1. No streak or idle logic exists, and StreakLength and IdleTimeout_ns are unused.
- All other behaviour is identical in both builds.

## Structure
- Shared package value_editor_pkg contains:
  - enum logic [1:0] {Step1, Step10, Step100} for the step state;
  - the step lookup function mapping state to 1, 10 or 100;
  - the direction enum {DirNone, DirUp, DirDown}.
- One sub-module, value_editor_accel, holds the FSM, streak counter and idle counter. It is instantiated only under VALUE_EDITOR_ACCEL_EN.
- The top level holds the signed add/saturate datapath and the output registers.

## Test plan
Bench settings: MaxMagnitude=99, StreakLength=4, ClockPeriod_ns=20, IdleTimeout_ns=2000 (100 cycles).
- Reset, then 3 iUp pulses → magnitude 3, oNegative 0; each oUpdate lands one cycle after its pulse.
- From +2: iSigned, then 5 iDown with ACCEL_EN off → −7. Then iUp ×10 → +3, crossing zero with the sign cleared.
- ACCEL_EN on, 6 consecutive iUp from 0 → steps 1,1,1,1,10,10, giving 24. Then one iDown → 23 with step back to 1.
- ACCEL_EN on, 4 iUp, then a 100-cycle gap, then iUp → step is 1, not 10.
- iUp pulses from 95 → value stops at 99 with oAtLimit=1, and further iUp produces no oUpdate. iSigned → −99, oAtLimit stays 1.
- Corner cases:
  - iUp+iDown in the same cycle → no change.
  - iSigned+iUp in the same cycle → only the sign toggles.
  - iSigned at 0 → no strobe.
  - Reset asserted together with iUp → reset values, oUpdate 0.
